// File: rtl/pci_pkg.sv
// Shared PCI definitions: bus command codes, byte enables and the FSM state
// encoding used by both the initiator and the target debug state outputs.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'h6;
  localparam logic [3:0] CMD_MEM_WRITE = 4'h7;
  localparam logic [3:0] BE_ALL        = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_TURN = 3'd3,
    ST_REQ  = 3'd4
  } pci_state_e;

endpackage

// File: rtl/pci_initiator.sv
// PCI bus initiator for memory read/write bursts with master-abort detection.
// Optional arbitration handshake (reqn/gntn) is enabled by defining PCI_ARB_EN.
//
// state | meaning
// IDLE  | waiting for a local request with nonzero length
// REQ   | requesting the bus, waiting for gntn (PCI_ARB_EN only)
// ADDR  | address phase: FRAME# low, command on C/BE#, address on AD
// DATA  | data phases until the last transfer or a DEVSEL# timeout
// TURN  | one turnaround cycle with FRAME#/IRDY# released and AD floating
module pci_initiator
  import pci_pkg::*;
#(
  parameter int LEN_W          = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             framen,
  output logic [3:0]       cben,
  inout  wire  [31:0]      ad,
  output logic             irdyn,
  input  logic             trdyn,
  input  logic             devseln,
`ifdef PCI_ARB_EN
  output logic             reqn,
  input  logic             gntn,
`endif
  output logic [2:0]       state
);

  localparam int TMO_W = $clog2(DEVSEL_TIMEOUT + 1);

  pci_state_e       st_q, st_d;
  logic             cmd_wr;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] remaining, to_accept;
  logic [31:0]      wbuf;
  logic             wbuf_full;
  logic             devsel_seen;
  logic [TMO_W-1:0] tmo_cnt;
  logic             abort;

  logic             in_data, xfer, seen_now, tmo_hit, wr_load, ad_oe;
  logic [31:0]      ad_out;

  always_comb begin
    in_data  = (st_q == ST_DATA);
    irdyn    = !(in_data && (!cmd_wr || wbuf_full));
    xfer     = !irdyn && !trdyn;
    seen_now = devsel_seen || !devseln;
    // A transfer on the final timeout cycle wins over the abort.
    tmo_hit  = in_data && !seen_now && (tmo_cnt == TMO_W'(1)) && !xfer;
    wr_ready = in_data && cmd_wr && (!wbuf_full || xfer) && (to_accept != '0);
    wr_load  = wr_ready && wr_valid;
    framen   = !((st_q == ST_ADDR) ||
                 (in_data && !((remaining == LEN_W'(1)) && !irdyn)));
    cben     = (st_q == ST_ADDR) ? (cmd_wr ? CMD_MEM_WRITE : CMD_MEM_READ) : BE_ALL;
    ad_oe    = (st_q == ST_ADDR) || (in_data && cmd_wr && wbuf_full);
    ad_out   = (st_q == ST_ADDR) ? addr_q : wbuf;
    busy     = (st_q != ST_IDLE);
    state    = st_q;
`ifdef PCI_ARB_EN
    reqn     = (st_q != ST_REQ);
`endif
  end

  assign ad = ad_oe ? ad_out : 'z;

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: begin
        if (req && (len != '0)) begin
`ifdef PCI_ARB_EN
          st_d = ST_REQ;
`else
          st_d = ST_ADDR;
`endif
        end
      end
      ST_REQ: begin
`ifdef PCI_ARB_EN
        if (!gntn) st_d = ST_ADDR;
`else
        st_d = ST_IDLE;
`endif
      end
      ST_ADDR: st_d = ST_DATA;
      ST_DATA: begin
        if ((xfer && (remaining == LEN_W'(1))) || tmo_hit) st_d = ST_TURN;
      end
      ST_TURN: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      cmd_wr      <= 1'b0;
      addr_q      <= '0;
      remaining   <= '0;
      to_accept   <= '0;
      wbuf        <= '0;
      wbuf_full   <= 1'b0;
      devsel_seen <= 1'b0;
      tmo_cnt     <= '0;
      abort       <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      st_q     <= st_d;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if ((st_q == ST_IDLE) && req && (len != '0)) begin
        cmd_wr    <= wr;
        addr_q    <= addr;
        remaining <= len;
        to_accept <= wr ? len : '0;
        wbuf_full <= 1'b0;
        abort     <= 1'b0;
      end
      if (st_q == ST_ADDR) begin
        devsel_seen <= 1'b0;
        tmo_cnt     <= TMO_W'(DEVSEL_TIMEOUT);
      end
      if (in_data) begin
        devsel_seen <= seen_now;
        if (!seen_now && (tmo_cnt != '0)) tmo_cnt <= tmo_cnt - TMO_W'(1);
        if (xfer && (remaining != '0)) remaining <= remaining - LEN_W'(1);
        if (xfer && !cmd_wr) begin
          rd_data  <= ad;
          rd_valid <= 1'b1;
        end
        if (wr_load) begin
          wbuf      <= wr_data;
          wbuf_full <= 1'b1;
          to_accept <= to_accept - LEN_W'(1);
        end else if (xfer) begin
          wbuf_full <= 1'b0;
        end
        if (tmo_hit) abort <= 1'b1;
      end
      if (st_q == ST_TURN) begin
        done      <= 1'b1;
        err       <= abort;
        wbuf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: write/read bursts, local stall, master
// abort, reset mid-burst and (with PCI_ARB_EN) the bus request handshake.
module tb_pci_initiator;
  import pci_pkg::*;

  localparam int          DT    = 5;
  localparam logic [31:0] PROBE = 32'h3c3c_a5a5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  len = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready, rd_valid, busy, done, err, framen, irdyn;
  logic [31:0] rd_data;
  logic [3:0]  cben;
  logic        trdyn = 1'b1, devseln = 1'b1, gntn = 1'b1;
  logic [2:0]  state;
  logic        tgt_oe = 1'b0;
  logic [31:0] tgt_val = '0;
  wire  [31:0] ad;
`ifdef PCI_ARB_EN
  logic        reqn;
`endif

  assign ad = tgt_oe ? tgt_val : 'z;

  pci_initiator #(.LEN_W(4), .DEVSEL_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
    .framen(framen), .cben(cben), .ad(ad), .irdyn(irdyn), .trdyn(trdyn),
    .devseln(devseln),
`ifdef PCI_ARB_EN
    .reqn(reqn), .gntn(gntn),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] words [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a probe pattern from the target side; it reads back intact only if the DUT floats AD.
  task automatic check_z(input string tag);
    logic        so;
    logic [31:0] sv;
    so = tgt_oe; sv = tgt_val;
    tgt_oe = 1'b1; tgt_val = PROBE;
    #1;
    check(tag, ad, PROBE);
    tgt_oe = so; tgt_val = sv;
    #1;
  endtask

  task automatic run_burst(input string nm, input logic is_wr, input logic [31:0] a,
                           input int n, input logic rd_wait, input int wr_gap,
                           input logic dev_on, input int rst_at, input int gnt_wait);
    int   xfers = 0, loaded = 0, dcyc = 0, rdv = 0, addr_seen = 0, req_cyc = 0, gap_left = 0;
    logic fin = 1'b0, did_rst = 1'b0, xfer_now, exp_irdyn;
    logic [2:0] st;
    @(negedge clk);
    req = 1'b1; wr = is_wr; addr = a; len = 4'(n);
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clk);
      req = 1'b0;
      rst = 1'b0;
      st = state;
      gntn = 1'b1; devseln = 1'b1; trdyn = 1'b1; tgt_oe = 1'b0; wr_valid = 1'b0;
      if (st == ST_REQ) gntn = (req_cyc < gnt_wait);
      if (st == ST_DATA) begin
        devseln = !dev_on;
        if (dev_on) trdyn = !is_wr && rd_wait && (dcyc % 2 == 0);
        if (!is_wr && !trdyn) begin tgt_oe = 1'b1; tgt_val = words[xfers % 4]; end
      end
      if (is_wr) begin
        if (gap_left > 0) gap_left--;
        else wr_valid = (loaded < n);
        wr_data = words[loaded % 4];
      end
      #1;
      case (st)
        ST_REQ: begin
          req_cyc++;
          check({nm, " req framen"}, 32'(framen), 32'd1);
`ifdef PCI_ARB_EN
          check({nm, " req reqn"}, 32'(reqn), 32'd0);
`endif
        end
        ST_ADDR: begin
          addr_seen++;
          check({nm, " addr ad"}, ad, a);
          check({nm, " addr cben"}, 32'(cben), is_wr ? 32'h7 : 32'h6);
          check({nm, " addr framen"}, 32'(framen), 32'd0);
          check({nm, " addr irdyn"}, 32'(irdyn), 32'd1);
`ifdef PCI_ARB_EN
          check({nm, " addr reqn"}, 32'(reqn), 32'd1);
`endif
        end
        ST_DATA: begin
          exp_irdyn = is_wr ? (loaded == xfers) : 1'b0;
          xfer_now  = !exp_irdyn && !trdyn;
          check({nm, " data irdyn"}, 32'(irdyn), 32'(exp_irdyn));
          check({nm, " data framen"}, 32'(framen), 32'((n - xfers == 1) && !exp_irdyn));
          check({nm, " data cben"}, 32'(cben), 32'h0);
          if (is_wr) begin
            check({nm, " wr_ready"}, 32'(wr_ready),
                  32'(((loaded == xfers) || xfer_now) && (loaded < n)));
            if (!exp_irdyn) check({nm, " wr ad"}, ad, words[xfers % 4]);
          end
          if (xfer_now && xfers == rst_at) begin rst = 1'b1; did_rst = 1'b1; end
          if (xfer_now) xfers++;
          if (is_wr && wr_valid && wr_ready) begin
            loaded++;
            if (loaded == 1) gap_left = wr_gap;
          end
          if ((is_wr && exp_irdyn) || (!is_wr && trdyn)) check_z({nm, " data ad float"});
          dcyc++;
        end
        ST_TURN: begin
          check({nm, " turn framen"}, 32'(framen), 32'd1);
          check({nm, " turn irdyn"}, 32'(irdyn), 32'd1);
          check({nm, " turn wr_ready"}, 32'(wr_ready), 32'd0);
          check_z({nm, " turn ad float"});
        end
        default: begin
          fin = 1'b1;
          check({nm, " end busy"}, 32'(busy), 32'd0);
          check({nm, " end state"}, 32'(state), 32'd0);
          if (did_rst) begin
            check({nm, " rst done"}, 32'(done), 32'd0);
            check({nm, " rst framen"}, 32'(framen), 32'd1);
            check({nm, " rst irdyn"}, 32'(irdyn), 32'd1);
            check({nm, " rst wr_ready"}, 32'(wr_ready), 32'd0);
            check({nm, " rst rd_valid"}, 32'(rd_valid), 32'd0);
            check_z({nm, " rst ad float"});
          end else begin
            check({nm, " done"}, 32'(done), 32'd1);
            check({nm, " err"}, 32'(err), 32'(!dev_on));
          end
        end
      endcase
      if (rd_valid && !did_rst) begin
        check({nm, " rd_data"}, rd_data, words[rdv % 4]);
        rdv++;
      end
    end
    check({nm, " finished in budget"}, 32'(fin), 32'd1);
    check({nm, " addr phases"}, 32'(addr_seen), 32'd1);
`ifdef PCI_ARB_EN
    check({nm, " req cycles"}, 32'(req_cyc), 32'(gnt_wait + 1));
`else
    check({nm, " req cycles"}, 32'(req_cyc), 32'd0);
`endif
    if (rst_at < 0) begin
      check({nm, " transfers"}, 32'(xfers), dev_on ? 32'(n) : 32'd0);
      check({nm, " rd_valid pulses"}, 32'(rdv), (!is_wr && dev_on) ? 32'(n) : 32'd0);
    end
    if (!dev_on) check({nm, " data cycles before abort"}, 32'(dcyc), 32'(DT));
    @(negedge clk);
    #1;
    check({nm, " done single pulse"}, 32'(done), 32'd0);
    check({nm, " idle after"}, 32'(state), 32'd0);
  endtask

  initial begin
    words[0] = 32'h5555_0000; words[1] = 32'h5555_1111;
    words[2] = 32'h5555_2222; words[3] = 32'h5555_3333;
    repeat (3) @(negedge clk);
    #1;
    check("reset framen", 32'(framen), 32'd1);
    check("reset irdyn", 32'(irdyn), 32'd1);
    check("reset cben", 32'(cben), 32'h0);
    check("reset wr_ready", 32'(wr_ready), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset state", 32'(state), 32'd0);
`ifdef PCI_ARB_EN
    check("reset reqn", 32'(reqn), 32'd1);
`endif
    check_z("reset ad float");
    @(negedge clk);
    rst = 1'b0;

    // A zero-length request must be ignored.
    req = 1'b1; wr = 1'b1; len = 4'd0;
    @(negedge clk);
    req = 1'b0;
    #1;
    check("len0 state", 32'(state), 32'd0);
    check("len0 busy", 32'(busy), 32'd0);

    run_burst("write", 1'b1, 32'hffff_fff0, 3, 1'b0, 0, 1'b1, -1, 0);
    run_burst("read",  1'b0, 32'h0000_1000, 3, 1'b1, 0, 1'b1, -1, 0);
    run_burst("stall", 1'b1, 32'h0000_2000, 2, 1'b0, 3, 1'b1, -1, 0);
    run_burst("abort", 1'b0, 32'h0000_3000, 3, 1'b0, 0, 1'b0, -1, 0);
    run_burst("rstmid", 1'b1, 32'h0000_4000, 3, 1'b0, 0, 1'b1, 1, 0);
    run_burst("after_rst", 1'b0, 32'h0000_5000, 2, 1'b0, 0, 1'b1, -1, 0);
`ifdef PCI_ARB_EN
    run_burst("arb", 1'b1, 32'h0000_6000, 1, 1'b0, 0, 1'b1, -1, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
PCI bus initiator (master) for memory read and write bursts. It is the requesting end of the same bus that pci_target_mem serves.
- Accepts a local request (command, address, word count).
- Runs one PCI address phase, then N data phases.
- Streams write data from, or read data to, a local valid/ready interface.
- Reports completion, or master abort when no target claims the cycle.

Parameters:
LEN_W, 4, width of the burst word count (1..2^LEN_W-1 words).
DEVSEL_TIMEOUT, 5, data-phase cycles to wait for devseln before master abort.

Ports:
clk  in  1  bus clock; all state changes on rising edge.
rst  in  1  synchronous reset, active-high.
req  in  1  start request; sampled only in IDLE.
wr  in  1  1 = memory write (cben 4'h7), 0 = memory read (cben 4'h6); captured with req.
addr  in  32  burst start address; captured with req.
len  in  LEN_W  number of data phases; captured with req.
wr_data  in  32  local write word.
wr_valid  in  1  wr_data valid.
wr_ready  out  1  wr_data consumed this cycle.
rd_data  out  32  read word captured from ad.
rd_valid  out  1  one-cycle pulse per read word.
busy  out  1  transaction in progress.
done  out  1  one-cycle pulse at end of transaction.
err  out  1  valid with done; 1 = master abort.
framen  out  1  PCI FRAME#, active-low.
cben  out  4  PCI C/BE#: command in address phase, 4'h0 (all bytes) in data phases.
ad  inout  32  PCI AD, tri-stated when not driven.
irdyn  out  1  PCI IRDY#, active-low.
trdyn  in  1  PCI TRDY#, from target.
devseln  in  1  PCI DEVSEL#, from target.
state  out  3  FSM state for debug (IDLE=0, ADDR=1, DATA=2, TURN=3, REQ=4).

Behaviour:
- Reset values: framen=1, irdyn=1, cben=4'h0, ad=Z, wr_ready=0, rd_valid=0, busy=0, done=0, err=0, state=IDLE.
- Transfer: a data transfer occurs on a rising edge where irdyn=0 and trdyn=0.
- IDLE: on req with len!=0, capture wr/addr/len, set busy, go to ADDR. A req with len==0 is ignored. A req while busy is ignored.
- ADDR (exactly 1 cycle): framen=0, cben=command, ad=addr. Then go to DATA; clear the devsel-seen flag and the timeout counter.
- DATA, write:
  - One-word buffer wbuf.
  - wr_ready = (!wbuf_full or transfer this cycle) and words still to accept > 0; the word loads when wr_valid & wr_ready.
  - irdyn=0 and ad=wbuf only while wbuf_full; otherwise irdyn=1 and ad=Z.
- DATA, read:
  - ad=Z, irdyn=0.
  - On each transfer, rd_data<=ad, and rd_valid pulses the following cycle.
- framen in DATA: 0, except 1 when remaining==1 and irdyn=0 (last data phase). Once deasserted it stays 1 until the transfer.
- Wait states: trdyn=1 with irdyn=0 holds ad/irdyn/framen unchanged. remaining decrements only on a transfer.
- Last transfer: go to TURN; irdyn=1, framen=1, ad=Z for 1 cycle. Then IDLE with done=1 and err=0; busy clears in the same cycle.
- devseln: latched once low. If still unseen after DEVSEL_TIMEOUT DATA cycles, master abort:
  - next cycle framen=1, irdyn=1;
  - go to TURN, then done=1, err=1;
  - remaining write data is discarded (wr_ready=0).
- Write stall: if wr_valid stays low, irdyn stays 1 indefinitely; the timeout still applies if devseln was never seen.
- Reset mid-burst: all outputs return to reset values on the next edge; no done pulse; buffered data is dropped.
- Counter widths: remaining is LEN_W bits and never wraps; it is only decremented when nonzero.

Optional Feature:
Macro PCI_ARB_EN.
- Defined:
  - Adds ports reqn (out, 1, reset 1) and gntn (in, 1).
  - IDLE goes to REQ on an accepted req; reqn=0 in REQ.
  - REQ goes to ADDR when gntn=0 is sampled; reqn returns to 1 in ADDR.
  - If gntn deasserts during DATA, the burst still completes.
- Not defined: no reqn/gntn ports; the REQ state is unreachable and IDLE goes directly to ADDR.

Decomposition:
- Shared package pci_pkg holds:
  - CMD_MEM_READ=4'h6, CMD_MEM_WRITE=4'h7, BE_ALL=4'h0;
  - the 3-bit state encoding, shared with the target's state output.
- No sub-module: the FSM, counters and write buffer stay in one module.

Test Plan:
1. Write burst: wr=1, addr=32'hfffffff0, len=3, wr_data 55550000/55551111/55552222; target holds trdyn=0, devseln=0 -> ADDR shows ad=fffffff0, cben=7; three transfers in order; framen rises on the 3rd data phase; done=1, err=0.
2. Read burst: wr=0, len=3, target returns 55550000/55551111/55552222 with trdyn=1 between words -> cben=6 in ADDR; rd_valid pulses exactly 3 times with those values; irdyn held 0 through the wait states.
3. Local stall: write len=2 with wr_valid low for 3 cycles before word 2 -> irdyn=1 and ad=Z during the gap, no extra transfer, done after word 2.
4. Master abort: devseln held 1 -> framen/irdyn release 5 DATA cycles after ADDR; done=1, err=1; returns to IDLE.
5. Reset mid-burst: assert rst during the 2nd data phase -> next edge framen=1, irdyn=1, ad=Z, busy=0, no done pulse.
6. PCI_ARB_EN build: gntn held 1 for 4 cycles -> reqn=0 and no framen activity; gntn=0 -> ADDR on the next cycle and reqn returns to 1.
